// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan code set 2 tables, break prefix, FSM state types
// and the ASCII-to-scancode mapping used by both the transmit and receive paths.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  localparam logic [7:0] PS2_LETTER_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  // Digits use the keypad codes so the receive decoder maps them back uniquely
  localparam logic [7:0] PS2_DIGIT_CODES [10] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  typedef enum logic [1:0] {TX_IDLE, TX_BIT_HI, TX_BIT_LO, TX_GAP} frame_state_t;
  typedef enum logic {KB_IDLE, KB_SEND} kb_state_t;

  function automatic logic [8:0] ascii_to_scancode(input logic [7:0] ascii);
    logic [7:0] idx;
    idx = 8'h00;
    ascii_to_scancode = 9'h000;
    if (ascii >= 8'h41 && ascii <= 8'h5A) begin
      idx = ascii - 8'h41;
      ascii_to_scancode = {1'b1, PS2_LETTER_CODES[idx[4:0]]};
    end else if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      idx = ascii - 8'h61;
      ascii_to_scancode = {1'b1, PS2_LETTER_CODES[idx[4:0]]};
    end else if (ascii >= 8'h30 && ascii <= 8'h39) begin
      idx = ascii - 8'h30;
      ascii_to_scancode = {1'b1, PS2_DIGIT_CODES[idx[3:0]]};
    end
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit device-to-host PS/2 frame followed by an idle gap.
// A start seen in the last gap cycle chains the next frame without a bubble.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       done
);

  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  frame_state_t  state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [10:0]   shreg;

  assign done = (state == TX_GAP) && (cnt == CW'(GAP_CYCLES - 1));

  // Bit 0 of shreg is always the bit currently on the data line
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= TX_IDLE;
      cnt        <= '0;
      bit_idx    <= 4'd0;
      shreg      <= '0;
      ps2_clk_o  <= 1'b1;
      ps2_data_o <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            shreg      <= {1'b1, ~^data, data, 1'b0};
            ps2_data_o <= 1'b0;
            ps2_clk_o  <= 1'b1;
            bit_idx    <= 4'd0;
            cnt        <= '0;
            state      <= TX_BIT_HI;
          end
        end
        TX_BIT_HI: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt       <= '0;
            ps2_clk_o <= 1'b0;
            state     <= TX_BIT_LO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TX_BIT_LO: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt       <= '0;
            ps2_clk_o <= 1'b1;
            if (bit_idx == 4'd10) begin
              ps2_data_o <= 1'b1;
              state      <= TX_GAP;
            end else begin
              bit_idx    <= bit_idx + 4'd1;
              shreg      <= {1'b0, shreg[10:1]};
              ps2_data_o <= shreg[1];
              state      <= TX_BIT_HI;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TX_GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (start) begin
              shreg      <= {1'b1, ~^data, data, 1'b0};
              ps2_data_o <= 1'b0;
              bit_idx    <= 4'd0;
              state      <= TX_BIT_HI;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// PS/2 keyboard emulator: maps accepted ASCII characters to scan codes and sends them.
// Define PS2_TX_BREAK_EN to follow each make code with F0 and the code again.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       busy,
  output logic       unsupported
);

  kb_state_t  state;
  logic       ready_q;
  logic       start_q;
  logic [7:0] code_q;
  logic [8:0] mapped;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] tx_byte;

  assign mapped      = ascii_to_scancode(ascii_in);
  assign ascii_ready = ready_q & ~reset;

`ifdef PS2_TX_BREAK_EN
  logic [1:0] byte_idx;
  logic       more_bytes;

  // Later bytes are handed over in the final gap cycle so frames stay back to back
  assign more_bytes = (byte_idx != 2'd2);
  assign tx_start   = start_q | (tx_done & more_bytes);
  assign tx_byte    = start_q ? code_q : ((byte_idx == 2'd0) ? PS2_BREAK_PREFIX : code_q);
`else
  assign tx_start = start_q;
  assign tx_byte  = code_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= KB_IDLE;
      ready_q     <= 1'b1;
      start_q     <= 1'b0;
      code_q      <= 8'h00;
      busy        <= 1'b0;
      unsupported <= 1'b0;
`ifdef PS2_TX_BREAK_EN
      byte_idx    <= 2'd0;
`endif
    end else begin
      start_q     <= 1'b0;
      unsupported <= 1'b0;
      case (state)
        KB_IDLE: begin
          if (ascii_valid && ready_q) begin
            if (mapped[8]) begin
              code_q  <= mapped[7:0];
              start_q <= 1'b1;
              busy    <= 1'b1;
              ready_q <= 1'b0;
              state   <= KB_SEND;
`ifdef PS2_TX_BREAK_EN
              byte_idx <= 2'd0;
`endif
            end else begin
              unsupported <= 1'b1;
            end
          end
        end
        KB_SEND: begin
          if (tx_done) begin
`ifdef PS2_TX_BREAK_EN
            if (more_bytes) begin
              byte_idx <= byte_idx + 2'd1;
            end else begin
              state   <= KB_IDLE;
              busy    <= 1'b0;
              ready_q <= 1'b1;
            end
`else
            state   <= KB_IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
`endif
          end
        end
        default: state <= KB_IDLE;
      endcase
    end
  end

  ps2_frame_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_frame_tx (
    .clk        (clk),
    .reset      (reset),
    .start      (tx_start),
    .data       (tx_byte),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_data_o (ps2_data_o),
    .done       (tx_done)
  );

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: a host-side PS/2 receiver model decodes
// the lines and results are compared with a table-driven model of the key mapping.
module tb_ps2_keyboard_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int FRAME   = 22 * CLK_DIV + GAP;
`ifdef PS2_TX_BREAK_EN
  localparam int NFRAMES = 3;
`else
  localparam int NFRAMES = 1;
`endif

  localparam logic [7:0] LETTER_TBL [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };
  localparam logic [7:0] DIGIT_TBL [10] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  logic       clk;
  logic       reset;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       ps2_clk_o;
  logic       ps2_data_o;
  logic       busy;
  logic       unsupported;

  ps2_keyboard_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .ps2_clk_o   (ps2_clk_o),
    .ps2_data_o  (ps2_data_o),
    .busy        (busy),
    .unsupported (unsupported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: {valid, code} from the character ranges and code tables
  function automatic logic [8:0] model_code(input logic [7:0] c);
    int i;
    i = int'(c);
    if (i >= 65 && i <= 90)  return {1'b1, LETTER_TBL[i - 65]};
    if (i >= 97 && i <= 122) return {1'b1, LETTER_TBL[i - 97]};
    if (i >= 48 && i <= 57)  return {1'b1, DIGIT_TBL[i - 48]};
    return 9'h000;
  endfunction

  // Receive-side decode: scan code back to uppercase ASCII, '?' when unknown
  function automatic logic [7:0] model_decode(input logic [7:0] code);
    for (int k = 0; k < 26; k++) if (LETTER_TBL[k] == code) return 8'(65 + k);
    for (int k = 0; k < 10; k++) if (DIGIT_TBL[k] == code) return 8'(48 + k);
    return 8'h3F;
  endfunction

  function automatic logic [7:0] upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    return c;
  endfunction

  // Cycle counter and acceptance log, sampled at the rising edge
  int cycle        = 0;
  int accept_cycle = -1;
  int accept_cnt   = 0;
  always @(posedge clk) begin
    cycle = cycle + 1;
    if (ascii_valid && ascii_ready) begin
      accept_cycle = cycle;
      accept_cnt++;
    end
  end

  // Host-side PS/2 receiver: samples data on each falling edge of ps2_clk_o
  logic       prev_c = 1'b1;
  logic       prev_d = 1'b1;
  int         bit_cnt = 0;
  logic [10:0] frm;
  logic [7:0] rx_q[$];
  int         fall_q[$];
  int         frame_err = 0;
  int         viol = 0;
  int         clk_edges = 0;
  int         data_edges = 0;
  always @(negedge clk) begin
    if (reset) begin
      bit_cnt = 0;
    end else begin
      if (ps2_clk_o !== prev_c) clk_edges++;
      if (ps2_data_o !== prev_d) data_edges++;
      if (prev_c == 1'b0 && ps2_clk_o == 1'b0 && ps2_data_o !== prev_d) viol++;
      if (prev_c == 1'b1 && ps2_clk_o == 1'b0) begin
        fall_q.push_back(cycle);
        frm[bit_cnt] = ps2_data_o;
        if (bit_cnt == 10) begin
          if (frm[0] !== 1'b0 || frm[10] !== 1'b1 || (^frm[9:1]) !== 1'b1) frame_err++;
          rx_q.push_back(frm[8:1]);
          bit_cnt = 0;
        end else begin
          bit_cnt++;
        end
      end
    end
    prev_c = ps2_clk_o;
    prev_d = ps2_data_o;
  end

  task automatic waitReady(input string tag, output int rise_cycle);
    int n;
    n = 0;
    while (!ascii_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n < 4000), 32'd1);
    rise_cycle = cycle;
  endtask

  task automatic checkFrames(input logic [7:0] ch, input logic [7:0] code);
    logic [7:0] exp_q[$];
    exp_q.push_back(code);
`ifdef PS2_TX_BREAK_EN
    exp_q.push_back(8'hF0);
    exp_q.push_back(code);
`endif
    checkOutput("frame_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      checkOutput($sformatf("frame_byte_%0d_ch%02h", i, ch), rx_q[i], exp_q[i]);
    if (rx_q.size() > 0)
      checkOutput($sformatf("loopback_ch%02h", ch), model_decode(rx_q[0]), upper(ch));
  endtask

  // Send one character (called at a falling clock edge) and check the whole response
  task automatic applyStimulus(input logic [7:0] ch);
    logic [8:0] m;
    int acc, rise, ce0, de0;
    m = model_code(ch);
    rx_q.delete();
    fall_q.delete();
    ce0 = clk_edges;
    de0 = data_edges;
    ascii_in    = ch;
    ascii_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ascii_valid = 1'b0;
    acc = accept_cycle;
    checkOutput("accepted", 32'(acc), 32'(cycle));
    if (m[8]) begin
      checkOutput("busy", busy, 1'b1);
      checkOutput("ready_low", ascii_ready, 1'b0);
      waitReady("done", rise);
      checkOutput("ready_latency", 32'(rise - acc), 32'(1 + NFRAMES * FRAME));
      checkOutput("busy_end", busy, 1'b0);
      checkOutput("first_fall", (fall_q.size() > 0) ? 32'(fall_q[0] - acc) : 32'hFFFF_FFFF, 32'd5);
`ifdef PS2_TX_BREAK_EN
      if (fall_q.size() >= 12)
        checkOutput("frame_spacing", 32'(fall_q[11] - fall_q[0]), 32'(FRAME));
`endif
      checkFrames(ch, m[7:0]);
    end else begin
      checkOutput("unsup_pulse", unsupported, 1'b1);
      checkOutput("unsup_ready", ascii_ready, 1'b1);
      checkOutput("unsup_busy", busy, 1'b0);
      @(negedge clk);
      checkOutput("unsup_clear", unsupported, 1'b0);
      repeat (20) @(negedge clk);
      checkOutput("unsup_no_edges", 32'(clk_edges - ce0 + data_edges - de0), 32'd0);
      checkOutput("unsup_no_frames", rx_q.size(), 32'd0);
    end
  endtask

  initial begin
    int acc1, acc2, cnt0, n, rise, target;
    logic [7:0] ch;
    string sweep;
    string pool;

    reset       = 1'b1;
    ascii_valid = 1'b0;
    ascii_in    = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_clk", ps2_clk_o, 1'b1);
    checkOutput("reset_data", ps2_data_o, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", ascii_ready, 1'b1);
    checkOutput("reset_unsup", unsupported, 1'b0);

    // 'A' directed
    applyStimulus(8'h41);

    // 'a' followed by '7' held valid while busy
    rx_q.delete();
    ascii_in    = 8'h61;
    ascii_valid = 1'b1;
    cnt0 = accept_cnt;
    @(posedge clk);
    @(negedge clk);
    acc1 = accept_cycle;
    ascii_in = 8'h37;
    n = 0;
    while (accept_cnt < cnt0 + 2 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ascii_valid = 1'b0;
    acc2 = accept_cycle;
    checkOutput("held_timeout", 32'(n < 4000), 32'd1);
    checkOutput("held_accept_gap", 32'(acc2 - acc1), 32'(2 + NFRAMES * FRAME));
    @(negedge clk);
    waitReady("held_done", rise);
    checkOutput("held_frames", rx_q.size(), 32'(2 * NFRAMES));
    if (rx_q.size() == 2 * NFRAMES) begin
      checkOutput("held_code1", rx_q[0], 8'h1C);
      checkOutput("held_code2", rx_q[NFRAMES], 8'h6C);
    end

    // Unsupported directed, then back-to-back unsupported every cycle
    applyStimulus(8'h23);
    cnt0 = accept_cnt;
    ascii_valid = 1'b1;
    ascii_in = 8'h23;
    @(posedge clk); @(negedge clk);
    ascii_in = 8'h24;
    @(posedge clk); @(negedge clk);
    ascii_in = 8'h25;
    @(posedge clk); @(negedge clk);
    ascii_valid = 1'b0;
    checkOutput("unsup_b2b_count", 32'(accept_cnt - cnt0), 32'd3);
    checkOutput("unsup_b2b_pulse", unsupported, 1'b1);
    checkOutput("unsup_b2b_ready", ascii_ready, 1'b1);
    @(negedge clk);

    // Reset in the middle of a frame, then a clean 'Z'
    rx_q.delete();
    fall_q.delete();
    ascii_in    = 8'h5A;
    ascii_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ascii_valid = 1'b0;
    target = (NFRAMES > 1) ? 17 : 6;
    n = 0;
    while (fall_q.size() < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midreset_timeout", 32'(n < 4000), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_clk", ps2_clk_o, 1'b1);
    checkOutput("midreset_data", ps2_data_o, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_ready", ascii_ready, 1'b1);
    checkOutput("midreset_partial", rx_q.size(), 32'(NFRAMES > 1 ? 1 : 0));
    repeat (60) @(negedge clk);
    checkOutput("midreset_quiet", rx_q.size(), 32'(NFRAMES > 1 ? 1 : 0));
    applyStimulus(8'h5A);

    // Loopback sweep over every uppercase letter and digit
    sweep = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    for (int i = 0; i < sweep.len(); i++) applyStimulus(sweep[i]);

    // Randomized mix of supported and arbitrary characters
    pool = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) ch = pool[$urandom_range(0, pool.len() - 1)];
      else ch = 8'($urandom_range(0, 255));
      applyStimulus(ch);
    end

    checkOutput("frame_format", 32'(frame_err), 32'd0);
    checkOutput("data_while_clk_low", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
